// File: rtl/vector_cfg_csr_unit.sv
// Vector configuration and CSR unit: executes vset* requests once the VPU has drained,
// and holds vstart/vxsat/vxrm/vcsr/vl/vtype/vlenb for decode and the VPU.
module vector_cfg_csr_unit #(
  parameter  int unsigned VLEN = 128,
  parameter  int unsigned ELEN = 32,
  localparam int unsigned VLW  = $clog2(VLEN) + 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cfg_valid_i,
  output logic           cfg_ready_o,
  input  logic [1:0]     cfg_op_i,
  input  logic [31:0]    avl_i,
  input  logic [4:0]     uimm_i,
  input  logic [31:0]    vtype_req_i,
  input  logic           rs1_zero_i,
  input  logic           rd_zero_i,
  input  logic           vpu_busy_i,
  output logic           cfg_done_o,
  output logic [31:0]    cfg_rd_o,
  input  logic           csr_we_i,
  input  logic [1:0]     csr_op_i,
  input  logic [11:0]    csr_addr_i,
  input  logic [31:0]    csr_wdata_i,
  output logic [31:0]    csr_rdata_o,
  output logic           csr_illegal_o,
  input  logic           vstart_we_i,
  input  logic [VLW-2:0] vstart_i,
  input  logic           vxsat_set_i,
  output logic [2:0]     vsew_o,
  output logic [2:0]     vlmul_o,
  output logic [VLW-1:0] vl_o,
  output logic [VLW-1:0] vlmax_o,
  output logic [VLW-2:0] vstart_o,
  output logic [1:0]     vxrm_o,
  output logic           vxsat_o,
  output logic [31:0]    vtype_o
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t         state, state_next;
  logic           accept, commit;
  logic [1:0]     req_op;
  logic [31:0]    req_avl, req_vtype;
  logic [4:0]     req_uimm;
  logic           req_rs1z, req_rdz;
  logic [VLW-1:0] vl_q, vl_next, new_vlmax;
  logic [31:0]    vtype_q, vtype_next, vlmax_ext, uimm_ext;
  logic [VLW-2:0] vstart_q;
  logic [1:0]     vxrm_q;
  logic           vxsat_q, vxsat_next, done_q, new_ill;
  logic [31:0]    csr_old, csr_new;
  logic           csr_mapped, csr_ro, csr_modifies, csr_write;
  logic           unused_csr_bits;

  function automatic logic vtype_ill(input logic [31:0] vt);
    logic [31:0] sew_bits;
    sew_bits  = 32'd8 << vt[5:3];
    vtype_ill = (|vt[30:8]) || vt[5] || (vt[2:0] == 3'b100) || (sew_bits > ELEN);
    // Fractional LMUL: SEW/LMUL must still fit within ELEN
    case (vt[2:0])
      3'b101:  if ((sew_bits << 3) > ELEN) vtype_ill = 1'b1;
      3'b110:  if ((sew_bits << 2) > ELEN) vtype_ill = 1'b1;
      3'b111:  if ((sew_bits << 1) > ELEN) vtype_ill = 1'b1;
      default: ;
    endcase
  endfunction

  function automatic logic [VLW-1:0] calc_vlmax(input logic [2:0] vsew, input logic [2:0] vlmul);
    logic [31:0] base;
    base = VLEN >> (32'(vsew) + 32'd3);
    case (vlmul)
      3'b000, 3'b001, 3'b010, 3'b011: base = base << vlmul;
      3'b101:  base = base >> 3;
      3'b110:  base = base >> 2;
      3'b111:  base = base >> 1;
      default: base = '0;
    endcase
    return base[VLW-1:0];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cfg_ready_o = (state == IDLE);
    accept      = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: if (cfg_valid_i) begin
        accept     = 1'b1;
        state_next = DRAIN;
      end
      DRAIN: if (!vpu_busy_i) begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign new_ill   = vtype_ill(req_vtype);
  assign new_vlmax = calc_vlmax(req_vtype[5:3], req_vtype[2:0]);
  assign vlmax_ext = {{(32-VLW){1'b0}}, new_vlmax};
  assign uimm_ext  = {27'b0, req_uimm};

  always_comb begin
    vl_next    = new_vlmax;
    vtype_next = {24'b0, req_vtype[7:0]};
    if (new_ill) begin
      vl_next    = '0;
      vtype_next = 32'h8000_0000;
    end else if (req_op == 2'd1) begin
      if (uimm_ext < vlmax_ext) vl_next = uimm_ext[VLW-1:0];
    end else if (!req_rs1z) begin
      if (req_avl < vlmax_ext) vl_next = req_avl[VLW-1:0];
    end else if (req_rdz) begin
      if (vl_q < new_vlmax) vl_next = vl_q;
    end
  end

  always_comb begin
    csr_mapped = 1'b1;
    csr_ro     = 1'b0;
    csr_old    = '0;
    case (csr_addr_i)
      12'h008: csr_old = {{(33-VLW){1'b0}}, vstart_q};
      12'h009: csr_old = {31'b0, vxsat_q};
      12'h00A: csr_old = {30'b0, vxrm_q};
      12'h00F: csr_old = {29'b0, vxrm_q, vxsat_q};
      12'hC20: begin csr_old = {{(32-VLW){1'b0}}, vl_q}; csr_ro = 1'b1; end
      12'hC21: begin csr_old = vtype_q;                  csr_ro = 1'b1; end
      12'hC22: begin csr_old = 32'(VLEN / 8);            csr_ro = 1'b1; end
      default: csr_mapped = 1'b0;
    endcase
    // Set/clear with a zero operand is a pure read and never counts as a write
    csr_new      = csr_old;
    csr_modifies = 1'b0;
    case (csr_op_i)
      2'd0: begin csr_new = csr_wdata_i;            csr_modifies = csr_we_i; end
      2'd1: begin csr_new = csr_old | csr_wdata_i;  csr_modifies = csr_we_i && (csr_wdata_i != '0); end
      2'd2: begin csr_new = csr_old & ~csr_wdata_i; csr_modifies = csr_we_i && (csr_wdata_i != '0); end
      default: ;
    endcase
    csr_write  = csr_modifies && csr_mapped && !csr_ro;
    vxsat_next = vxsat_q;
    if (csr_write && (csr_addr_i == 12'h009 || csr_addr_i == 12'h00F)) vxsat_next = csr_new[0];
    vxsat_next = vxsat_next | vxsat_set_i;
  end

  assign csr_rdata_o     = csr_old;
  assign csr_illegal_o   = !csr_mapped || (csr_modifies && csr_ro);
  assign unused_csr_bits = &{1'b0, csr_new};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_op    <= '0;
      req_avl   <= '0;
      req_uimm  <= '0;
      req_vtype <= '0;
      req_rs1z  <= 1'b0;
      req_rdz   <= 1'b0;
      vl_q      <= '0;
      vtype_q   <= 32'h8000_0000;
      vstart_q  <= '0;
      vxrm_q    <= '0;
      vxsat_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q  <= commit;
      vxsat_q <= vxsat_next;
      if (accept) begin
        req_op    <= cfg_op_i;
        req_avl   <= avl_i;
        req_uimm  <= uimm_i;
        req_vtype <= vtype_req_i;
        req_rs1z  <= rs1_zero_i;
        req_rdz   <= rd_zero_i;
      end
      if (commit) begin
        vl_q    <= vl_next;
        vtype_q <= vtype_next;
      end
      if (commit)                                  vstart_q <= '0;
      else if (csr_write && csr_addr_i == 12'h008) vstart_q <= csr_new[VLW-2:0];
      else if (vstart_we_i)                        vstart_q <= vstart_i;
      if (csr_write && csr_addr_i == 12'h00A)      vxrm_q <= csr_new[1:0];
      else if (csr_write && csr_addr_i == 12'h00F) vxrm_q <= csr_new[2:1];
    end
  end

  assign cfg_done_o = done_q;
  assign cfg_rd_o   = {{(32-VLW){1'b0}}, vl_q};
  assign vl_o       = vl_q;
  assign vtype_o    = vtype_q;
  assign vsew_o     = vtype_q[5:3];
  assign vlmul_o    = vtype_q[2:0];
  assign vlmax_o    = vtype_q[31] ? '0 : calc_vlmax(vtype_q[5:3], vtype_q[2:0]);
  assign vstart_o   = vstart_q;
  assign vxrm_o     = vxrm_q;
  assign vxsat_o    = vxsat_q;

endmodule
